neuron_state_mem_ctrl: RTL and testbench

Parametrised successor to the membrane-potential/beta SRAM glue in the neuron core.
- Sits between the layer controller and the potential/beta SRAM macros.
- Registers the write port and tracks read latency with a valid pipeline.
- Forwards pending potential writes to same-address reads (read-modify-write hazard).
- Adds a hardware clear sequencer that zeroes all potential words, one per cycle.

---
 rtl/neuron_mem_pkg.sv | 17 +
 rtl/mem_rd_fwd_pipe.sv | 82 ++++++++
 rtl/neuron_state_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_neuron_state_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mem_pkg.sv
// Shared defaults and clear-sequencer state encoding for the neuron
// membrane-potential / beta SRAM controller.
package neuron_mem_pkg;

  localparam int unsigned POT_W_DEF  = 128;
  localparam int unsigned BETA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DEPTH_DEF  = 512;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/mem_rd_fwd_pipe.sv
// Read-response valid pipeline with write-history forwarding. The forwarding
// decision is made when the read is accepted and then carried along with it.
module mem_rd_fwd_pipe #(
  parameter int unsigned POT_W  = 128,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              rd_fire_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [POT_W-1:0]  wr_data_i,
  input  logic [POT_W-1:0]  sram_rd_data_i,
  output logic              rd_valid_o,
  output logic [POT_W-1:0]  pot_rd_data_o
);

  // Entry 0 mirrors the SRAM write register; the older RD_LAT entries cover
  // writes that may still be racing the SRAM read.
  localparam int unsigned HIST = RD_LAT + 1;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [POT_W-1:0]  data;
  } wr_ent_t;

  typedef struct packed {
    logic             vld;
    logic             hit;
    logic [POT_W-1:0] data;
  } rd_ent_t;

  wr_ent_t          hist_q [HIST];
  rd_ent_t          pipe_q [RD_LAT];
  logic             fwd_hit;
  logic [POT_W-1:0] fwd_data;

  // Walk oldest to newest so the newest match wins; same-cycle write is newest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = int'(HIST) - 1; i >= 0; i--) begin
      if (hist_q[i].vld && (hist_q[i].addr == rd_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = hist_q[i].data;
      end
    end
    if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HIST); i++) hist_q[i] <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
    end else begin
      hist_q[0].vld  <= wr_fire_i && !flush_i;
      hist_q[0].addr <= wr_addr_i;
      hist_q[0].data <= wr_data_i;
      for (int i = 1; i < int'(HIST); i++) begin
        hist_q[i].vld  <= hist_q[i-1].vld && !flush_i;
        hist_q[i].addr <= hist_q[i-1].addr;
        hist_q[i].data <= hist_q[i-1].data;
      end
      pipe_q[0].vld  <= rd_fire_i;
      pipe_q[0].hit  <= fwd_hit;
      pipe_q[0].data <= fwd_data;
      for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rd_valid_o    = pipe_q[RD_LAT-1].vld;
  assign pot_rd_data_o = !pipe_q[RD_LAT-1].vld ? '0 :
                         pipe_q[RD_LAT-1].hit  ? pipe_q[RD_LAT-1].data : sram_rd_data_i;

endmodule

// File: rtl/neuron_state_mem_ctrl.sv
// Glue between the layer controller and the potential/beta SRAM macros:
// registered write port, pipelined reads with forwarding, hardware clear.
module neuron_state_mem_ctrl
  import neuron_mem_pkg::*;
#(
  parameter int unsigned POT_W  = POT_W_DEF,
  parameter int unsigned BETA_W = BETA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [POT_W-1:0]  pot_rd_data,
  output logic [BETA_W-1:0] beta_rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [POT_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] pot_sram_rd_addr,
  input  logic [POT_W-1:0]  pot_sram_rd_data,
  output logic [ADDR_W-1:0] beta_sram_rd_addr,
  input  logic [BETA_W-1:0] beta_sram_rd_data,
  output logic [ADDR_W-1:0] pot_sram_wr_addr,
  output logic [POT_W-1:0]  pot_sram_wr_data,
  output logic              pot_sram_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_we_q, wr_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [POT_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              idle, rd_fire, wr_fire, flush;

  assign idle       = (state_q == IDLE);
  assign rd_ready   = idle;
  assign wr_ready   = idle;
  assign rd_fire    = rd_req && idle;
  assign wr_fire    = wr_req && idle;
  assign flush      = clear_start && idle;
  assign clear_busy = !idle;
  assign clear_done = (state_q == DONE);

  // The SRAM write register is shared by user writes and the clear sweep.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_we_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (wr_fire) begin
          wr_we_d   = 1'b1;
          wr_addr_d = wr_addr;
          wr_data_d = wr_data;
        end
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        wr_we_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        if (cnt_q == LAST_ADDR) state_d = DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_we_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_we_q   <= wr_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (rd_fire) rd_addr_q <= rd_addr;
    end
  end

  assign pot_sram_we       = wr_we_q;
  assign pot_sram_wr_addr  = wr_addr_q;
  assign pot_sram_wr_data  = wr_data_q;
  assign pot_sram_rd_addr  = rd_fire ? rd_addr : rd_addr_q;
  assign beta_sram_rd_addr = rd_fire ? rd_addr : rd_addr_q;

  mem_rd_fwd_pipe #(
    .POT_W  (POT_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_fwd (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .rd_fire_i      (rd_fire),
    .rd_addr_i      (rd_addr),
    .wr_fire_i      (wr_fire),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .sram_rd_data_i (pot_sram_rd_data),
    .rd_valid_o     (rd_valid),
    .pot_rd_data_o  (pot_rd_data)
  );

  assign beta_rd_data = rd_valid ? beta_sram_rd_data : '0;

endmodule

// File: tb/tb_neuron_state_mem_ctrl.sv
// Directed bench for neuron_state_mem_ctrl with a read-first SRAM model.
module tb_neuron_state_mem_ctrl;

  localparam int POT_W  = 128;
  localparam int BETA_W = 64;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear_start = 1'b0;
  logic              clear_busy, clear_done;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready, rd_valid;
  logic [POT_W-1:0]  pot_rd_data;
  logic [BETA_W-1:0] beta_rd_data;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [POT_W-1:0]  wr_data = '0;
  logic              wr_ready;
  logic [ADDR_W-1:0] pot_sram_rd_addr, beta_sram_rd_addr, pot_sram_wr_addr;
  logic [POT_W-1:0]  pot_sram_rd_data, pot_sram_wr_data;
  logic [BETA_W-1:0] beta_sram_rd_data;
  logic              pot_sram_we;

  always #5 clk = ~clk;

  neuron_state_mem_ctrl #(
    .POT_W(POT_W), .BETA_W(BETA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .pot_rd_data(pot_rd_data), .beta_rd_data(beta_rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .pot_sram_rd_addr(pot_sram_rd_addr), .pot_sram_rd_data(pot_sram_rd_data),
    .beta_sram_rd_addr(beta_sram_rd_addr), .beta_sram_rd_data(beta_sram_rd_data),
    .pot_sram_wr_addr(pot_sram_wr_addr), .pot_sram_wr_data(pot_sram_wr_data),
    .pot_sram_we(pot_sram_we)
  );

  // SRAM model: address sampled at the edge (read-first), RD_LAT cycles to data.
  logic [POT_W-1:0]  pot_mem  [DEPTH];
  logic [BETA_W-1:0] beta_mem [DEPTH];
  logic [POT_W-1:0]  s_pot    [RD_LAT];
  logic [BETA_W-1:0] s_beta   [RD_LAT];
  logic              pre_pw = 1'b0, pre_bw = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [POT_W-1:0]  pre_pot = '0;
  logic [BETA_W-1:0] pre_beta = '0;

  always @(posedge clk) begin
    if (pot_sram_we) pot_mem[pot_sram_wr_addr] <= pot_sram_wr_data;
    if (pre_pw) pot_mem[pre_addr] <= pre_pot;
    if (pre_bw) beta_mem[pre_addr] <= pre_beta;
    s_pot[0]  <= pot_mem[pot_sram_rd_addr];
    s_beta[0] <= beta_mem[beta_sram_rd_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      s_pot[i]  <= s_pot[i-1];
      s_beta[i] <= s_beta[i-1];
    end
  end
  assign pot_sram_rd_data  = s_pot[RD_LAT-1];
  assign beta_sram_rd_data = s_beta[RD_LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [POT_W-1:0] act, input logic [POT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic pw, input logic bw, input logic [ADDR_W-1:0] a,
                         input logic [POT_W-1:0] p, input logic [BETA_W-1:0] b);
    pre_pw = pw; pre_bw = bw; pre_addr = a; pre_pot = p; pre_beta = b;
    tick();
    pre_pw = 1'b0; pre_bw = 1'b0;
  endtask

  typedef struct {
    logic              pp_en;
    logic              pb_en;
    logic [ADDR_W-1:0] pre_a;
    logic [POT_W-1:0]  pre_p;
    logic [BETA_W-1:0] pre_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wa;
    logic [POT_W-1:0]  wd;
    logic [ADDR_W-1:0] ra;
    logic [POT_W-1:0]  exp_p;
    logic [BETA_W-1:0] exp_b;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int busy_n, wr_n, done_n, bad_n, leak_n;
  logic found;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 9'd5,   {16{8'hA5}}, 64'h1234, 1'b0, 9'd0, 128'h0,  9'd5,   {16{8'hA5}}, 64'h1234};
    vecs[1] = '{1'b1, 1'b1, 9'd7,   128'hDEAD,   64'h77,   1'b1, 9'd7, 128'h55, 9'd7,   128'h55,     64'h77};
    vecs[2] = '{1'b1, 1'b1, 9'd9,   128'h99,     64'h9,    1'b1, 9'd8, 128'h88, 9'd9,   128'h99,     64'h9};
    vecs[3] = '{1'b0, 1'b1, 9'd8,   128'h0,      64'h8,    1'b0, 9'd0, 128'h0,  9'd8,   128'h88,     64'h8};
    vecs[4] = '{1'b1, 1'b1, 9'd511, '1,          '1,       1'b0, 9'd0, 128'h0,  9'd511, '1,          '1};
    vecs[5] = '{1'b1, 1'b1, 9'd0,   128'hF,      64'h0,    1'b1, 9'd0, 128'h1,  9'd0,   128'h1,      64'h0};
    vecs[6] = '{1'b0, 1'b0, 9'd0,   128'h0,      64'h0,    1'b1, 9'd7, 128'h66, 9'd5,   {16{8'hA5}}, 64'h1234};
    vecs[7] = '{1'b0, 1'b0, 9'd0,   128'h0,      64'h0,    1'b0, 9'd0, 128'h0,  9'd7,   128'h66,     64'h77};

    // Reset state
    repeat (3) tick();
    chk("rst_we", pot_sram_we, 1'b0);
    chk("rst_busy", clear_busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_pot_rd_data", pot_rd_data, '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_rd_ready", rd_ready, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);

    // Table vectors: read (optionally with a same-cycle write), checked at T+RD_LAT
    for (int v = 0; v < NV; v++) begin
      preload(vecs[v].pp_en, vecs[v].pb_en, vecs[v].pre_a, vecs[v].pre_p, vecs[v].pre_b);
      rd_req = 1'b1; rd_addr = vecs[v].ra;
      wr_req = vecs[v].wr_en; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
      #1;
      chk($sformatf("v%0d_sram_rd_addr", v), pot_sram_rd_addr, vecs[v].ra);
      tick();
      rd_req = 1'b0; wr_req = 1'b0;
      chk($sformatf("v%0d_rd_valid_early", v), rd_valid, 1'b0);
      chk($sformatf("v%0d_sram_we", v), pot_sram_we, vecs[v].wr_en);
      if (vecs[v].wr_en) begin
        chk($sformatf("v%0d_sram_wr_addr", v), pot_sram_wr_addr, vecs[v].wa);
        chk($sformatf("v%0d_sram_wr_data", v), pot_sram_wr_data, vecs[v].wd);
      end
      tick();
      chk($sformatf("v%0d_rd_valid", v), rd_valid, 1'b1);
      chk($sformatf("v%0d_pot", v), pot_rd_data, vecs[v].exp_p);
      chk($sformatf("v%0d_beta", v), beta_rd_data, vecs[v].exp_b);
      chk($sformatf("v%0d_rd_addr_hold", v), pot_sram_rd_addr, vecs[v].ra);
      tick(); tick();
    end

    // Back-to-back writes to addr 3, then reads of 3 and 4 on consecutive cycles
    preload(1'b1, 1'b1, 9'd3, 128'h33, 64'h3);
    preload(1'b1, 1'b1, 9'd4, 128'h44, 64'h4);
    wr_req = 1'b1; wr_addr = 9'd3; wr_data = 128'h11;
    tick();
    chk("b2b_we0", pot_sram_we, 1'b1);
    chk("b2b_data0", pot_sram_wr_data, 128'h11);
    wr_data = 128'h22;
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 9'd3;
    tick();
    rd_addr = 9'd4;
    chk("b2b_valid_early", rd_valid, 1'b0);
    tick();
    rd_req = 1'b0;
    chk("b2b_valid3", rd_valid, 1'b1);
    chk("b2b_pot3", pot_rd_data, 128'h22);
    chk("b2b_beta3", beta_rd_data, 64'h3);
    tick();
    chk("b2b_valid4", rd_valid, 1'b1);
    chk("b2b_pot4", pot_rd_data, 128'h44);
    chk("b2b_beta4", beta_rd_data, 64'h4);
    tick();
    chk("b2b_valid_end", rd_valid, 1'b0);
    tick(); tick();

    // Full clear sweep with blocked requests and an ignored second clear_start
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    rd_req = 1'b1; rd_addr = 9'd7; wr_req = 1'b1; wr_addr = 9'd1; wr_data = 128'hBAD;
    busy_n = 0; wr_n = 0; done_n = 0; bad_n = 0; leak_n = 0;
    for (int c = 0; c < 700; c++) begin
      clear_start = (c == 200);
      if (!clear_busy) break;
      busy_n++;
      if (pot_sram_we) begin
        if (pot_sram_wr_addr != 9'(wr_n) || pot_sram_wr_data != '0) bad_n++;
        wr_n++;
      end
      if (rd_valid || rd_ready || wr_ready) leak_n++;
      if (clear_done) begin
        done_n++;
        rd_req = 1'b0; wr_req = 1'b0;
      end
      tick();
    end
    clear_start = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    chk("clr_busy_cycles", 128'(busy_n), 128'(DEPTH + 1));
    chk("clr_writes", 128'(wr_n), 128'(DEPTH));
    chk("clr_done_pulses", 128'(done_n), 128'd1);
    chk("clr_bad_writes", 128'(bad_n), 128'd0);
    chk("clr_accepts", 128'(leak_n), 128'd0);
    chk("clr_idle_after", clear_busy, 1'b0);
    chk("clr_ready_after", rd_ready, 1'b1);

    rd_req = 1'b1; rd_addr = 9'd7;
    tick();
    rd_addr = 9'd5;
    tick();
    rd_req = 1'b0;
    chk("postclr_valid7", rd_valid, 1'b1);
    chk("postclr_pot7", pot_rd_data, '0);
    chk("postclr_beta7", beta_rd_data, 64'h77);
    tick();
    chk("postclr_pot5", pot_rd_data, '0);
    chk("postclr_beta5", beta_rd_data, 64'h1234);
    tick();

    // Reset in the middle of a clear sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pot_sram_we && pot_sram_wr_addr == 9'd100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("midclr_reached_100", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_rst_we", pot_sram_we, 1'b0);
    chk("midclr_rst_busy", clear_busy, 1'b0);
    chk("midclr_rst_done", clear_done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("midclr_rd_ready", rd_ready, 1'b1);
    chk("midclr_busy_after", clear_busy, 1'b0);
    chk("midclr_we_after", pot_sram_we, 1'b0);
    rd_req = 1'b1; rd_addr = 9'd5;
    tick();
    rd_req = 1'b0;
    tick();
    chk("midclr_read_valid", rd_valid, 1'b1);
    chk("midclr_read_beta", beta_rd_data, 64'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
